fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter sequencer and fetch controller for the 32-bit instruction memory.
//  - Drives the memory byte address each cycle. The memory returns Memory[PC/4] one clock later (registered read).
//  - Tracks which address is in flight and presents {instr, pc} to decode with a valid/ready handshake.
//  - Handles decode back-pressure, branch/jump redirects, halt and misaligned-redirect faults.
// PARAMETERS
//  PC_WIDTH  6  byte-address width of imem_pc; PC wraps modulo 2**PC_WIDTH.
//  RESET_PC  0  first fetch address after reset; must be a multiple of 4.
// PORTS
//  clock           in   1         rising-edge clock shared with instruction memory
//  reset           in   1         synchronous, active-high
//  imem_pc         out  PC_WIDTH  byte address to instruction memory (combinational, see BEHAVIOUR)
//  imem_instr      in   32        memory data: word for imem_pc of previous cycle
//  if_valid        out  1         {if_instr, if_pc} hold a fetched word
//  if_ready        in   1         decode accepts the word this cycle
//  if_instr        out  32        fetched instruction (= imem_instr)
//  if_pc           out  PC_WIDTH  byte address of if_instr
//  redirect_valid  in   1         taken branch/jump this cycle
//  redirect_pc     in   PC_WIDTH  redirect target byte address
//  halt_req        in   1         stop fetching (level)
//  halted          out  1         in HALT state
//  fault           out  1         sticky misaligned-redirect error
// BEHAVIOUR
//  Registers: state, pc_q (next sequential address), rsp_v, rsp_pc (address whose word is on imem_instr).
//  if_valid = rsp_v & (state==RUN); if_pc = rsp_pc; if_instr = imem_instr.
//  States: BOOT -> RUN; RUN -> HALT; RUN -> FAULT; HALT -> RUN; FAULT -> (reset only).
//  Reset: next edge gives state=BOOT, rsp_v=0, pc_q=RESET_PC, halted=0, fault=0.
//    imem_pc is RESET_PC while in BOOT.
//  BOOT (1 cycle): present RESET_PC. Next: RUN, rsp_v=1, rsp_pc=RESET_PC, pc_q=RESET_PC+4.
//  RUN imem_pc mux, priority high->low:
//    1. redirect_valid      -> redirect_pc
//    2. if_valid&!if_ready  -> rsp_pc (re-read; word stays stable)
//    3. otherwise           -> pc_q
//    Edge update: rsp_pc<=imem_pc; rsp_v<=1; pc_q<=imem_pc+4 (mod 2**PC_WIDTH).
//  Throughput: one word per cycle with if_ready held high. Latency: redirect -> target on if_valid = 1 cycle.
//  Redirect: the current word is dropped even if if_ready=1 in the same cycle (decode must not also consume it).
//  Misaligned redirect (redirect_pc[1:0]!=0) -> FAULT, checked before the redirect:
//    rsp_v<=0, fault<=1, imem_pc holds last value, redirect ignored.
//  Halt: in RUN with halt_req=1 and no redirect, if the current word is accepted or none is valid -> HALT, rsp_v<=0.
//    A stalled word is never lost by halt.
//  HALT: halted=1, if_valid=0, imem_pc=pc_q.
//    halt_req=0 -> RUN next edge; first word appears 1 cycle later at pc_q.
//    redirect_valid in HALT -> updates pc_q only (stays halted).
//  Priority in one cycle: reset > fault > redirect > halt > stall.
//  Wrap: pc 2**PC_WIDTH-4 is followed by 0 (60 -> 0 for PC_WIDTH=6).
//  imem_pc combinational path from if_ready/redirect_valid is intentional (no fetch bubble).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    adds out ports perf_fetched[15:0] (accepted words) and perf_stall[15:0] (cycles with if_valid&!if_ready).
//    Both saturate at 16'hFFFF, cleared by reset, frozen in FAULT.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset then if_ready=1 for 5 cycles -> if_pc 0,4,8,12 on consecutive cycles; if_instr=Memory[if_pc/4].
//  - if_ready=0 for 3 cycles at if_pc=8 -> if_pc=8 and if_instr stable; release -> next pc 12, no gap.
//  - redirect_valid with redirect_pc=40 while if_pc=4 -> next cycle if_pc=40; word at 4 not counted as accepted.
//  - Straight-line run from 56 -> if_pc 56,60,0,4 (wrap).
//  - redirect_pc=6 -> fault=1 and if_valid=0 next cycle; stays until reset; reset mid-FAULT -> BOOT, fetch from 0.
//  - halt_req during stall at if_pc=20 -> word 20 held until accepted, then halted=1.
//    Deassert halt_req -> fetch resumes at 24.
//    With FETCH_PERF_CNT_EN: perf_stall equals the stalled cycle count.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, decode and control signals of the fetch sequencer.
interface fetch_sequencer_if #(parameter int PC_WIDTH = 6);
    logic [PC_WIDTH-1:0] imem_pc;
    logic [PC_WIDTH-1:0] if_pc;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] if_instr;
    logic if_valid;
    logic if_ready;
    logic redirect_valid;
    logic halt_req;
    logic halted;
    logic fault;
    modport master (
        output imem_pc, if_valid, if_instr, if_pc, halted, fault,
        input imem_instr, if_ready, redirect_valid, redirect_pc, halt_req
    );
    modport slave (
        input imem_pc, if_valid, if_instr, if_pc, halted, fault,
        output imem_instr, if_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer and fetch controller for a registered-read instruction memory.
// Defining FETCH_PERF_CNT_EN adds saturating accepted-word and stall-cycle counters.
module fetch_sequencer #(
    parameter int PC_WIDTH = 6,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic clock,
    input logic reset,
    fetch_sequencer_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
    state_t state;
    logic [PC_WIDTH-1:0] pc_q, rsp_pc, next_pc;
    logic rsp_v, stall, misaligned, halted, fault;
    always_comb begin
        misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        stall = bus.if_valid && !bus.if_ready;
        next_pc = state == BOOT ? RESET_PC :
                  state == HALT ? pc_q :
                  (state == FAULT || misaligned) ? rsp_pc :
                  bus.redirect_valid ? bus.redirect_pc :
                  stall ? rsp_pc : pc_q;
    end
    assign bus.imem_pc = next_pc;
    assign bus.if_valid = rsp_v && (state == RUN);
    assign bus.if_pc = rsp_pc;
    assign bus.if_instr = bus.imem_instr;
    assign bus.halted = halted;
    assign bus.fault = fault;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            rsp_v <= 1'b0;
            rsp_pc <= RESET_PC;
            pc_q <= RESET_PC;
            halted <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    rsp_v <= 1'b1;
                    rsp_pc <= RESET_PC;
                    pc_q <= RESET_PC + PC_WIDTH'(4);
                end
                RUN: begin
                    if (misaligned) begin
                        state <= FAULT;
                        rsp_v <= 1'b0;
                        fault <= 1'b1;
                    end else if (!bus.redirect_valid && bus.halt_req && !stall) begin
                        state <= HALT;
                        rsp_v <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        rsp_pc <= next_pc;
                        rsp_v <= 1'b1;
                        pc_q <= next_pc + PC_WIDTH'(4);
                    end
                end
                HALT: begin
                    if (misaligned) begin
                        state <= FAULT;
                        halted <= 1'b0;
                        fault <= 1'b1;
                    end else if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end else if (!bus.halt_req) begin
                        // memory already holds pc_q from the HALT cycle, so the word is valid at once
                        state <= RUN;
                        halted <= 1'b0;
                        rsp_v <= 1'b1;
                        rsp_pc <= pc_q;
                        pc_q <= pc_q + PC_WIDTH'(4);
                    end
                end
                default: ;
            endcase
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall <= '0;
        end else if (state != FAULT) begin
            // a word dropped by a redirect is not counted as accepted
            if (bus.if_valid && bus.if_ready && !bus.redirect_valid && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (stall && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif
endmodule
